// File: rtl/mlp_seq_engine.sv
// Time-multiplexed N_IN-N_HID-N_OUT perceptron: one signed MAC walks every neuron in turn,
// streaming weights/biases in address order from an external 1-cycle-latency coefficient memory.
module mlp_seq_engine #(
  parameter int N_IN  = 60,
  parameter int N_HID = 5,
  parameter int N_OUT = 2,
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int AW    = 10,
  localparam int KW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_IN*W-1:0]  uzorak,
  output logic [AW-1:0]      coef_addr,
  input  logic [W-1:0]       coef_data,
  output logic               busy,
  output logic               done,
  output logic [N_OUT*W-1:0] izlaz,
  output logic [N_OUT-1:0]   indikator,
  output logic [KW-1:0]      klasa
);

  localparam int ACC_W = 2*W + $clog2(N_IN+1) + 1;
  localparam int NMAX  = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int CW    = $clog2(NMAX+2);
  localparam int NW    = $clog2(((N_HID > N_OUT) ? N_HID : N_OUT) + 1);
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_HID_MAC, S_HID_FIN, S_OUT_MAC, S_OUT_FIN, S_DONE
  } state_t;

  state_t                         r_state;
  logic [CW-1:0]                  r_cnt;
  logic [NW-1:0]                  r_nrn;
  logic [AW-1:0]                  r_addr;
  logic [N_IN-1:0][W-1:0]         r_smp;
  logic [N_HID-1:0][W-1:0]        r_hid;
  logic [N_OUT-1:0][W-1:0]        r_ob;
  logic signed [ACC_W-1:0]        r_acc;
  logic                           r_busy;
  logic                           r_done;
  logic [N_OUT-1:0][W-1:0]        r_izlaz;
  logic [N_OUT-1:0]               r_ind;
  logic [KW-1:0]                  r_klasa;

  logic                           w_is_hid;
  logic [CW-1:0]                  w_last;
  logic [CW-1:0]                  w_opi;
  logic [W-1:0]                   w_op;
  logic signed [2*W-1:0]          w_prod;
  logic signed [ACC_W-1:0]        w_prod_x;
  logic signed [ACC_W-1:0]        w_bias_x;
  logic signed [ACC_W-1:0]        w_sh;
  logic [W-1:0]                   w_sat;
  logic [W-1:0]                   w_relu;
  logic [W-1:0]                   w_best;
  logic [KW-1:0]                  w_cls;
  logic [N_OUT-1:0]               w_ind;

  assign w_is_hid = (r_state == S_HID_MAC);
  assign w_last   = w_is_hid ? CW'(N_IN) : CW'(N_HID);
  // r_cnt counts cycles within a neuron; data returned at r_cnt=k belongs to address k-1
  assign w_opi    = r_cnt - 1'b1;

  always_comb begin
    w_op = '0;
    for (int i = 0; i < N_IN; i++)
      if (r_state == S_HID_MAC && w_opi == CW'(i)) w_op = r_smp[i];
    for (int j = 0; j < N_HID; j++)
      if (r_state == S_OUT_MAC && w_opi == CW'(j)) w_op = r_hid[j];
  end

  assign w_prod   = $signed(coef_data) * $signed(w_op);
  assign w_prod_x = ACC_W'(w_prod);
  assign w_bias_x = ACC_W'($signed(coef_data)) <<< FRAC;
  assign w_sh     = r_acc >>> FRAC;

  always_comb begin
    if (w_sh > SMAX)      w_sat = {1'b0, {(W-1){1'b1}}};
    else if (w_sh < SMIN) w_sat = {1'b1, {(W-1){1'b0}}};
    else                  w_sat = w_sh[W-1:0];
  end

  assign w_relu = w_sat[W-1] ? '0 : w_sat;

  // strict compare keeps the lowest index on ties
  always_comb begin
    w_cls  = '0;
    w_best = r_ob[0];
    for (int k = 1; k < N_OUT; k++)
      if ($signed(r_ob[k]) > $signed(w_best)) begin
        w_best = r_ob[k];
        w_cls  = KW'(k);
      end
  end

  always_comb begin
    w_ind = '0;
    for (int k = 0; k < N_OUT; k++) w_ind[k] = r_ob[k][W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_nrn   <= '0;
      r_addr  <= '0;
      r_smp   <= '0;
      r_hid   <= '0;
      r_ob    <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_izlaz <= '0;
      r_ind   <= '0;
      r_klasa <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_smp   <= uzorak;
            r_busy  <= 1'b1;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_nrn   <= '0;
            r_acc   <= '0;
            r_state <= S_HID_MAC;
          end
        end
        S_HID_MAC, S_OUT_MAC: begin
          if (r_cnt < w_last) r_addr <= r_addr + 1'b1;
          if (r_cnt == w_last + 1'b1) begin
            r_acc   <= r_acc + w_bias_x;
            r_state <= w_is_hid ? S_HID_FIN : S_OUT_FIN;
          end else begin
            if (r_cnt != '0) r_acc <= r_acc + w_prod_x;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HID_FIN: begin
          // coefficients are laid out contiguously, so the next base is just the next address
          r_hid[r_nrn] <= w_relu;
          r_addr       <= r_addr + 1'b1;
          r_acc        <= '0;
          r_cnt        <= '0;
          if (r_nrn == NW'(N_HID-1)) begin
            r_nrn   <= '0;
            r_state <= S_OUT_MAC;
          end else begin
            r_nrn   <= r_nrn + 1'b1;
            r_state <= S_HID_MAC;
          end
        end
        S_OUT_FIN: begin
          r_ob[r_nrn] <= w_sat;
          r_addr      <= r_addr + 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          if (r_nrn == NW'(N_OUT-1)) begin
            r_nrn   <= '0;
            r_state <= S_DONE;
          end else begin
            r_nrn   <= r_nrn + 1'b1;
            r_state <= S_OUT_MAC;
          end
        end
        S_DONE: begin
          r_izlaz <= r_ob;
          r_ind   <= w_ind;
          r_klasa <= w_cls;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_addr  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign coef_addr = r_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign izlaz     = r_izlaz;
  assign indikator = r_ind;
  assign klasa     = r_klasa;

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Bench for mlp_seq_engine: directed and random networks checked against an integer reference model.
module tb_mlp_seq_engine;
  localparam int N_IN  = 60;
  localparam int N_HID = 5;
  localparam int N_OUT = 2;
  localparam int W     = 16;
  localparam int FRAC  = 8;
  localparam int AW    = 10;
  localparam int LAT   = 1 + N_HID*(N_IN+3) + N_OUT*(N_HID+3);
  localparam int OB    = N_HID*(N_IN+1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic [N_IN*W-1:0]  uzorak = '0;
  logic [AW-1:0]      coef_addr;
  logic [W-1:0]       coef_data = '0;
  logic               busy;
  logic               done;
  logic [N_OUT*W-1:0] izlaz;
  logic [N_OUT-1:0]   indikator;
  logic [0:0]         klasa;

  logic [W-1:0]       mem [0:(1<<AW)-1];
  logic [W-1:0]       feat [N_IN];
  logic [N_OUT*W-1:0] exp_izlaz, last_izlaz;
  logic [N_OUT-1:0]   exp_ind;
  logic [0:0]         exp_klasa;
  int                 n_vec = 0;
  int                 n_err = 0;

  mlp_seq_engine #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .W(W), .FRAC(FRAC), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .uzorak(uzorak),
    .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy), .done(done),
    .izlaz(izlaz), .indikator(indikator), .klasa(klasa)
  );

  always #5 clk = ~clk;
  always @(posedge clk) coef_data <= mem[coef_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Straight evaluation of the network from the coefficient map
  task automatic model();
    longint acc, v, best;
    longint hv [N_HID];
    for (int h = 0; h < N_HID; h++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) acc += sx(feat[i]) * sx(mem[h*(N_IN+1)+i]);
      acc += sx(mem[h*(N_IN+1)+N_IN]) * (longint'(1) << FRAC);
      v = sat(acc >>> FRAC);
      hv[h] = (v < 0) ? 0 : v;
    end
    best = 0;
    exp_klasa = '0;
    for (int o = 0; o < N_OUT; o++) begin
      acc = 0;
      for (int j = 0; j < N_HID; j++) acc += hv[j] * sx(mem[OB+o*(N_HID+1)+j]);
      acc += sx(mem[OB+o*(N_HID+1)+N_HID]) * (longint'(1) << FRAC);
      v = sat(acc >>> FRAC);
      exp_izlaz[o*W +: W] = W'(v);
      exp_ind[o] = (v < 0);
      if (o == 0 || v > best) begin
        best = v;
        exp_klasa = 1'(o);
      end
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < (1<<AW); a++) mem[a] = '0;
  endtask

  task automatic rand_feat(input int full);
    for (int i = 0; i < N_IN; i++)
      feat[i] = full ? W'($urandom) : W'(int'($urandom_range(0, 1023)) - 512);
  endtask

  task automatic rand_mem();
    clear_mem();
    for (int a = 0; a < OB + N_OUT*(N_HID+1); a++)
      mem[a] = W'(int'($urandom_range(0, 255)) - 128);
  endtask

  task automatic set_uz();
    for (int i = 0; i < N_IN; i++) uzorak[i*W +: W] = feat[i];
  endtask

  // Called at a negedge; leaves at the negedge after the done cycle
  task automatic run_inf(input string tag, input bit disturb);
    int n;
    bit seen;
    set_uz();
    start = 1'b1;
    @(posedge clk);
    n = 0;
    seen = 0;
    while (!seen && n <= LAT + 50) begin
      @(negedge clk);
      if (n == 0) begin
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_addr0"}, coef_addr, 0);
      end
      if (disturb && n == 10) begin
        start = 1'b1;
        for (int i = 0; i < N_IN; i++) uzorak[i*W +: W] = W'($urandom);
      end
      if (disturb && n == 11) start = 1'b0;
      if (n == 200) chk({tag, "_hold"}, izlaz, last_izlaz);
      if (done) seen = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_izlaz"}, izlaz, exp_izlaz);
    chk({tag, "_ind"}, indikator, exp_ind);
    chk({tag, "_klasa"}, klasa, exp_klasa);
    chk({tag, "_busy_lo"}, busy, 0);
    last_izlaz = exp_izlaz;
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int ndone;
    clear_mem();
    last_izlaz = '0;
    #1 rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_izlaz", izlaz, 0);
    chk("rst_ind", indikator, 0);
    chk("rst_klasa", klasa, 0);
    chk("rst_addr", coef_addr, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Bias-only network
    clear_mem();
    rand_feat(0);
    for (int h = 0; h < N_HID; h++) mem[h*(N_IN+1)+N_IN] = 16'h0100;
    mem[OB+N_HID]           = 16'hFF00;
    mem[OB+(N_HID+1)+N_HID] = 16'h0100;
    model();
    run_inf("bias", 0);
    chk("bias_spec_izlaz", izlaz, 32'h0100FF00);
    chk("bias_spec_ind", indikator, 2'b01);
    chk("bias_spec_klasa", klasa, 1);

    // ReLU clamps every hidden neuron; outputs tie at zero
    clear_mem();
    rand_feat(0);
    for (int h = 0; h < N_HID; h++) mem[h*(N_IN+1)+N_IN] = 16'hFE00;
    for (int o = 0; o < N_OUT; o++)
      for (int j = 0; j < N_HID; j++) mem[OB+o*(N_HID+1)+j] = 16'h0100;
    model();
    run_inf("relu", 0);
    chk("relu_spec_izlaz", izlaz, 32'h00000000);
    chk("relu_spec_klasa", klasa, 0);

    // Positive saturation
    clear_mem();
    for (int i = 0; i < N_IN; i++) feat[i] = 16'h7FFF;
    for (int h = 0; h < N_HID; h++)
      for (int i = 0; i < N_IN; i++) mem[h*(N_IN+1)+i] = 16'h7FFF;
    mem[OB] = 16'h0100;
    model();
    run_inf("sat", 0);
    chk("sat_spec_izlaz", izlaz, 32'h00007FFF);
    chk("sat_spec_klasa", klasa, 0);

    // Random networks, one with a stray start and sample change mid-run
    for (int r = 0; r < 6; r++) begin
      rand_mem();
      rand_feat(r % 3 == 2);
      model();
      run_inf($sformatf("rnd%0d", r), r == 2);
    end

    // Negative saturation through a large negative output bias
    rand_mem();
    rand_feat(0);
    mem[OB+N_HID] = 16'h8000;
    model();
    run_inf("negsat", 0);

    // Abort mid-run
    rand_mem();
    rand_feat(0);
    set_uz();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_izlaz", izlaz, 0);
    chk("abort_ind", indikator, 0);
    chk("abort_klasa", klasa, 0);
    chk("abort_addr", coef_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (400) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    last_izlaz = '0;
    model();
    run_inf("post_abort", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
